// File: rtl/window_minmax_4bit_pkg.sv
// Shared definitions for the windowed min/max tracker: FSM state type and width defaults.
package window_minmax_4bit_pkg;

    localparam int unsigned DataWDefault = 4;
    localparam int unsigned CntWDefault  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } wmm_state_e;

endpackage

// File: rtl/window_minmax_4bit_mag_cmp.sv
// Combinational unsigned magnitude comparator: flags a > b, a < b and a == b.
module mag_cmp
    import window_minmax_4bit_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/window_minmax_4bit.sv
// Tracks max/min of a window of win_len samples (0 = 2**CNT_W); IDLE -> RUN -> DONE.
// Optional max_cnt output (occurrences of the current max) enabled by WMM_MAX_COUNT_EN.
module window_minmax_4bit
    import window_minmax_4bit_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned CNT_W  = CntWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic              done,
    output logic              busy,
    output logic              result_valid
`ifdef WMM_MAX_COUNT_EN
    ,
    output logic [CNT_W:0]    max_cnt
`endif
);

    wmm_state_e state_q, state_d;

    logic [CNT_W:0]    len_q, cnt_q, len_full;
    logic [DATA_W-1:0] max_q, min_q;
    logic              rv_q;
    logic              start_win, accept, first, last;
    logic              max_gt, max_lt, max_eq;
    logic              min_gt, min_lt, min_eq;

    mag_cmp #(.DATA_W(DATA_W)) u_cmp_max (
        .a  (in_data),
        .b  (max_q),
        .gt (max_gt),
        .lt (max_lt),
        .eq (max_eq)
    );

    mag_cmp #(.DATA_W(DATA_W)) u_cmp_min (
        .a  (in_data),
        .b  (min_q),
        .gt (min_gt),
        .lt (min_lt),
        .eq (min_eq)
    );

    logic unused_cmp;
    assign unused_cmp = ^{max_lt, max_eq, min_gt, min_eq};

    // A zero length field stands for the full 2**CNT_W window, hence the extra count bit.
    assign len_full  = (win_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, win_len};
    assign start_win = (state_q == StIdle) && start;
    assign accept    = (state_q == StRun) && in_valid;
    assign first     = (cnt_q == '0);
    assign last      = accept && ((cnt_q + 1'b1) == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_win) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = (state_q == StRun);
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
            max_q <= '0;
            min_q <= '0;
            rv_q  <= 1'b0;
        end else begin
            if (start_win) begin
                len_q <= len_full;
                cnt_q <= '0;
                rv_q  <= 1'b0;
            end
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                if (first || max_gt) max_q <= in_data;
                if (first || min_lt) min_q <= in_data;
            end
            if (last) rv_q <= 1'b1;
        end
    end

`ifdef WMM_MAX_COUNT_EN
    logic [CNT_W:0] max_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_cnt_q <= '0;
        end else if (accept) begin
            if (first || max_gt) begin
                max_cnt_q <= {{CNT_W{1'b0}}, 1'b1};
            end else if (max_eq) begin
                max_cnt_q <= max_cnt_q + 1'b1;
            end
        end
    end

    assign max_cnt = max_cnt_q;
`endif

    assign max_val      = max_q;
    assign min_val      = min_q;
    assign result_valid = rv_q;

endmodule
